ysyx_23060236_ifu: RTL
======================

# ysyx_23060236_ifu

Instruction fetch unit of the ysyx_23060236 in-order RV32E pipeline. It sits directly upstream of the decode stage. It generates sequential fetch addresses and issues single-beat reads on an AXI4-Lite-style instruction read channel. Returned instructions are buffered with their PC in a 2-entry queue that feeds decode through a valid/ready handshake, and the whole frontend is flushed and redirected when the execute stage reports a mispredicted control transfer (`jump_wrong`).

## Interface
- RESET_PC, 32'h3000_0000, first fetch address after reset
- DEPTH, 2, instruction queue entries (power of two, ≥2)
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high; clock clock
- jump_wrong  in  1  redirect request from execute; flushes the frontend
- dnpc  in  32  redirect target, valid when jump_wrong=1
- arvalid  out  1  read address valid
- arready  in  1  read address accepted
- araddr  out  32  fetch address, word aligned
- rvalid  in  1  read data valid
- rready  out  1  read data ready
- rdata  in  32  instruction word
- rresp  in  2  response, 2'b00 = OKAY
- inst  out  32  instruction to decode
- pc  out  32  PC of `inst`
- idu_valid  out  1  `inst`/`pc` valid
- idu_ready  in  1  decode accepts

## Operation
- Address/read FSM with states:
  - **REQ**: arvalid=1, araddr=fetch_pc.
  - **WAIT**: rready=1.
  - **DROP**: rready=1; the response is discarded.
  - **HOLD**: no request issued; waiting for a queue credit.
- Credit rule: a new request leaves HOLD only when queue count + outstanding < DEPTH. At most 1 read is outstanding.
- Transitions:
  - HOLD→REQ when credit is available.
  - REQ→WAIT on arvalid&arready.
  - WAIT→HOLD/REQ on rvalid. The response is pushed as {fetch_pc, rdata} and fetch_pc += 4.
- Redirect on jump_wrong=1 in a given cycle:
  - The queue is flushed at the next edge and fetch_pc is set to dnpc.
  - From REQ with arready=0, araddr is held stable (AXI rule: no retraction). On acceptance the FSM goes to DROP. fetch_pc is already dnpc.
  - From REQ with arready=1, or from WAIT without rvalid: go to DROP.
  - From WAIT with rvalid in the same cycle: discard the data and go to HOLD.
  - DROP→HOLD on rvalid, with no push and fetch_pc unchanged.
  - A redirect during DROP only updates fetch_pc.
- rresp≠OKAY: push inst=32'h0010_0073 (ebreak) so simulation halts. The PC is unchanged.
- Output side:
  - idu_valid = ~empty & ~jump_wrong.
  - inst/pc always show the queue head.
  - Pop on idu_valid & idu_ready.
  - Push and pop may occur in the same cycle; count is unchanged.
- Arithmetic: fetch_pc wraps modulo 2^32. Queue pointers are log2(DEPTH) bits wide and wrap naturally.

## Timing
- Reset values:
  - FSM=HOLD, fetch_pc=RESET_PC, queue empty.
  - arvalid=0, rready=0, idu_valid=0.
  - araddr=RESET_PC, inst=0, pc=0.
- Reset takes priority over jump_wrong and over any in-flight response. Reset mid-transaction returns to HOLD; the bus is expected to be reset by the same signal.
- Minimum path from the first REQ cycle to idu_valid, with arready=1 and rvalid one cycle later: REQ at t, WAIT at t+1 with rvalid, push at the t+1 edge, idu_valid at t+2.
- Redirect penalty: jump_wrong at t gives arvalid with araddr=dnpc no earlier than t+1.
- Full queue: no request is issued, so no response is ever dropped for lack of space.
- With empty queue and idu_ready=0, the unit stalls without loss.

## Structure
- Shared package/defines (`ysyx_23060236_defines.v`):
  - IFU state encodings.
  - EBREAK constant 32'h0010_0073.
  - Default RESET_PC.
- Sub-module `ysyx_23060236_ifu_fifo`: parameterised {pc,inst} queue with push, pop, flush, count, empty and full.
- The FSM and fetch_pc register live in the top module.
- Estimated size: about 200 lines of RTL.

## Test plan
- Reset then free-running fetch: arready=1, rvalid one cycle later, idu_ready=1 → pc sequence 0x3000_0000, 0x3000_0004, 0x3000_0008, and inst equals the supplied rdata.
- Back-pressure: idu_ready=0 for 10 cycles → exactly 2 instructions buffered, arvalid stays 0 afterwards, no duplication or loss after release.
- Redirect during WAIT: jump_wrong=1 with dnpc=0x8000_0010 while a read to 0x3000_0008 is outstanding → that response is discarded, the next araddr is 0x8000_0010, and the first delivered pc is 0x8000_0010.
- Redirect with arvalid stalled (arready=0 for 3 cycles): jump_wrong pulses → araddr stays stable until accepted, the response is dropped, and the next request goes to dnpc.
- Error response: rresp=2'b10 → inst=32'h0010_0073 delivered with the faulting pc.
- Redirect coincident with rvalid and with a queue pop → no push occurs, the queue is empty next cycle, and idu_valid=0 in the jump_wrong cycle.

Source files
------------

// File: rtl/ysyx_23060236_ifu_pkg.sv
// Shared IFU types and constants: FSM encodings, queue entry layout, ebreak substitute word.
// The helper turns an AXI read beat into a queue entry, replacing faulting fetches with ebreak.
package ysyx_23060236_ifu_pkg;

    typedef enum logic [1:0] {
        IFU_HOLD = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2,
        IFU_DROP = 2'd3
    } ifu_state_t;

    localparam logic [31:0] EBREAK_INST      = 32'h0010_0073;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h3000_0000;
    localparam logic [1:0]  RESP_OKAY        = 2'b00;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } ifu_entry_t;

    function automatic ifu_entry_t make_entry(input logic [31:0] fpc,
                                              input logic [31:0] rdata,
                                              input logic [1:0]  rresp);
        ifu_entry_t e;
        e.pc   = fpc;
        e.inst = (rresp == RESP_OKAY) ? rdata : EBREAK_INST;
        return e;
    endfunction

endpackage

// File: rtl/ysyx_23060236_ifu_if.sv
// AXI4-Lite-style instruction read channel (AR + R only); the IFU is the master.
// Valid/ready on both channels, single beat per request.
interface ysyx_23060236_ifu_if;

    logic        arvalid;
    logic        arready;
    logic [31:0] araddr;
    logic        rvalid;
    logic        rready;
    logic [31:0] rdata;
    logic [1:0]  rresp;

    modport master (
        output arvalid, araddr, rready,
        input  arready, rvalid, rdata, rresp
    );

    modport slave (
        input  arvalid, araddr, rready,
        output arready, rvalid, rdata, rresp
    );

endinterface

// File: rtl/ysyx_23060236_ifu_fifo.sv
// {pc,inst} queue: push lands at the edge, head visible the next cycle; flush empties in one edge.
// Push is ignored when full and pop when empty; the caller's credit scheme keeps push off a full queue.
module ysyx_23060236_ifu_fifo
    import ysyx_23060236_ifu_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  ifu_entry_t               push_dat,
    input  logic                     pop,
    input  logic                     flush,
    output ifu_entry_t               head,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    ifu_entry_t    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ysyx_23060236_ifu.sv
// Instruction fetch: one outstanding AXI read, responses queued with their PC for decode.
// Request-to-idu_valid is 2 cycles minimum; no request is issued without a free queue slot.
module ysyx_23060236_ifu
    import ysyx_23060236_ifu_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          DEPTH    = 2
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    jump_wrong,
    input  logic [31:0]             dnpc,
    ysyx_23060236_ifu_if.master     bus,
    output logic [31:0]             inst,
    output logic [31:0]             pc,
    output logic                    idu_valid,
    input  logic                    idu_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifu_state_t     state;
    ifu_state_t     state_next;
    logic [31:0]    fetch_pc;
    logic [31:0]    fetch_pc_next;
    logic [31:0]    araddr_q;
    logic           drop_pending;
    logic           arvalid_o;
    logic           rready_o;

    logic           push;
    logic           pop;
    ifu_entry_t     push_dat;
    ifu_entry_t     head;
    logic [CW-1:0]  count;
    logic           empty;
    logic           full;
    logic           credit_after;
    logic [31:0]    dnpc_aligned;

    assign dnpc_aligned = {dnpc[31:2], 2'b00};

    // In WAIT the outstanding read already owns a slot, so the next request needs one more.
    assign credit_after = (count + CW'(1)) < CW'(DEPTH);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IFU_HOLD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IFU_HOLD: begin
                if (jump_wrong || !full) begin
                    state_next = IFU_REQ;
                end
            end
            IFU_REQ: begin
                if (bus.arready) begin
                    state_next = (jump_wrong || drop_pending) ? IFU_DROP : IFU_WAIT;
                end
            end
            IFU_WAIT: begin
                if (bus.rvalid) begin
                    state_next = (!jump_wrong && credit_after) ? IFU_REQ : IFU_HOLD;
                end else if (jump_wrong) begin
                    state_next = IFU_DROP;
                end
            end
            IFU_DROP: begin
                if (bus.rvalid) begin
                    state_next = IFU_HOLD;
                end
            end
            default: state_next = IFU_HOLD;
        endcase
    end

    always_comb begin
        arvalid_o = 1'b0;
        rready_o  = 1'b0;
        case (state)
            IFU_REQ:  arvalid_o = 1'b1;
            IFU_WAIT: rready_o  = 1'b1;
            IFU_DROP: rready_o  = 1'b1;
            default: begin
                arvalid_o = 1'b0;
                rready_o  = 1'b0;
            end
        endcase
    end

    assign bus.arvalid = arvalid_o;
    assign bus.rready  = rready_o;
    assign bus.araddr  = araddr_q;

    // A faulting fetch keeps fetch_pc so the substituted ebreak carries the faulting address.
    always_comb begin
        fetch_pc_next = fetch_pc;
        if (jump_wrong) begin
            fetch_pc_next = dnpc_aligned;
        end else if (state == IFU_WAIT && bus.rvalid && bus.rresp == RESP_OKAY) begin
            fetch_pc_next = fetch_pc + 32'd4;
        end
    end

    // araddr is captured only on entry to REQ so a redirect never moves a pending address.
    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc     <= RESET_PC;
            araddr_q     <= RESET_PC;
            drop_pending <= 1'b0;
        end else begin
            fetch_pc <= fetch_pc_next;
            if (state_next == IFU_REQ && state != IFU_REQ) begin
                araddr_q <= fetch_pc_next;
            end
            drop_pending <= (state == IFU_REQ) && !bus.arready && (drop_pending || jump_wrong);
        end
    end

    assign push      = (state == IFU_WAIT) && bus.rvalid && !jump_wrong;
    assign push_dat  = make_entry(fetch_pc, bus.rdata, bus.rresp);
    assign idu_valid = !empty && !jump_wrong;
    assign pop       = idu_valid && idu_ready;
    assign inst      = head.inst;
    assign pc        = head.pc;

    ysyx_23060236_ifu_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock    (clock),
        .reset    (reset),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .flush    (jump_wrong),
        .head     (head),
        .count    (count),
        .empty    (empty),
        .full     (full)
    );

endmodule
